data_memory_sized: RTL and testbench

Parametrised, byte-addressed, little-endian data memory for the 64-bit single-cycle/pipelined datapath. It replaces the fixed doubleword memory with sized accesses (byte/half/word/double) selected by the load/store funct3, and with sign or zero extension on loads. Reads are registered (1-cycle latency with a valid pulse), writes are synchronous, and misaligned or out-of-range accesses are flagged and suppressed. It sits at the MEM stage between the ALU result (address) and the write-back mux.

---
 rtl/data_memory_sized.sv | 158 +++++++++++++++
 tb/tb_data_memory_sized.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
// data_memory_sized
//
// Byte-addressed, little-endian data memory for the MEM stage of the 64-bit
// datapath. It supports byte, half, word and doubleword loads and stores,
// selected by the load/store funct3. Loads can be sign- or zero-extended.
//
// Timing behaviour:
//   - Loads are registered, with one cycle of latency and a one-cycle valid pulse.
//   - Stores are synchronous.
//   - Misaligned or out-of-range accesses are flagged for one cycle and are
//     not performed.
//
// Parameters:
//   DEPTH_BYTES  memory size in bytes (power of two, >= 8)
//   ADDR_WIDTH   width of Mem_Addr
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset; zeroes the memory and outputs
//   MemWrite     store request, sampled at the rising edge
//   MemRead      load request, sampled at the rising edge
//   Mem_Addr     byte address
//   Funct3       size / extension select (B,H,W,D,BU,HU,WU; 111 illegal)
//   Write_Data   store data, low 8/16/32/64 bits used
//   Read_Data    registered load result
//   Read_Valid   one-cycle pulse after every sampled load
//   Misaligned   last sampled access was not aligned to its size
//   AccessFault  last sampled access was out of range or used an illegal funct3

module data_memory_sized #(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [ADDR_WIDTH-1:0] Mem_Addr,
    input  logic [2:0]            Funct3,
    input  logic [63:0]           Write_Data,
    output logic [63:0]           Read_Data,
    output logic                  Read_Valid,
    output logic                  Misaligned,
    output logic                  AccessFault
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int EXT_W = ADDR_WIDTH + 1;
    localparam logic [EXT_W-1:0] DEPTH_EXT = EXT_W'(DEPTH_BYTES);

    logic [7:0]       mem [0:DEPTH_BYTES-1];

    logic             access_active;
    logic [7:0]       lane_en;
    logic [3:0]       size_bytes;
    logic             is_misaligned;
    logic             is_fault;
    logic             is_good;
    logic [EXT_W-1:0] end_addr;
    logic [IDX_W-1:0] base_idx;
    logic [63:0]      raw_bytes;
    logic [63:0]      load_value;

    // Decode the access size and classify the access. The end address is
    // computed one bit wider than Mem_Addr so that the addition cannot wrap.
    // Upper address bits therefore take part in the range check.
    always_comb begin
        access_active = MemRead | MemWrite;
        base_idx      = Mem_Addr[IDX_W-1:0];
        size_bytes    = 4'd1;
        lane_en       = 8'h01;
        is_misaligned = 1'b0;
        case (Funct3[1:0])
            2'b00: begin
                size_bytes    = 4'd1;
                lane_en       = 8'h01;
                is_misaligned = 1'b0;
            end
            2'b01: begin
                size_bytes    = 4'd2;
                lane_en       = 8'h03;
                is_misaligned = Mem_Addr[0];
            end
            2'b10: begin
                size_bytes    = 4'd4;
                lane_en       = 8'h0F;
                is_misaligned = |Mem_Addr[1:0];
            end
            default: begin
                size_bytes    = 4'd8;
                lane_en       = 8'hFF;
                is_misaligned = |Mem_Addr[2:0];
            end
        endcase
        is_misaligned = is_misaligned & access_active;
        end_addr      = {1'b0, Mem_Addr} + EXT_W'(size_bytes);
        is_fault      = access_active &
                        ((Funct3 == 3'b111) || (end_addr > DEPTH_EXT) ||
                         (MemWrite && Funct3[2]));
        is_good       = access_active & ~is_misaligned & ~is_fault;
    end

    // Gather the addressed bytes, then extend them to 64 bits.
    // Lanes above the access size are masked off. Their wrapped index is
    // never used.
    always_comb begin
        raw_bytes = '0;
        for (int k = 0; k < 8; k++) begin
            if (lane_en[k]) begin
                raw_bytes[8*k +: 8] = mem[base_idx + IDX_W'(k)];
            end
        end
        case (Funct3[1:0])
            2'b00: load_value = Funct3[2] ? {56'd0, raw_bytes[7:0]}
                                          : {{56{raw_bytes[7]}}, raw_bytes[7:0]};
            2'b01: load_value = Funct3[2] ? {48'd0, raw_bytes[15:0]}
                                          : {{48{raw_bytes[15]}}, raw_bytes[15:0]};
            2'b10: load_value = Funct3[2] ? {32'd0, raw_bytes[31:0]}
                                          : {{32{raw_bytes[31]}}, raw_bytes[31:0]};
            default: load_value = raw_bytes;
        endcase
    end

    // Storage array. Only a good store changes any byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (MemWrite && is_good) begin
            for (int k = 0; k < 8; k++) begin
                if (lane_en[k]) begin
                    mem[base_idx + IDX_W'(k)] <= Write_Data[8*k +: 8];
                end
            end
        end
    end

    // Registered outputs. A load in the same cycle as a store sees the
    // contents from before that store, because both blocks update at the
    // same edge. A rejected load returns zero but still pulses Read_Valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Read_Data   <= '0;
            Read_Valid  <= 1'b0;
            Misaligned  <= 1'b0;
            AccessFault <= 1'b0;
        end else begin
            if (MemRead) begin
                Read_Data <= is_good ? load_value : 64'd0;
            end
            Read_Valid  <= MemRead;
            Misaligned  <= is_misaligned;
            AccessFault <= is_fault;
        end
    end

endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized
//
// Self-checking bench for data_memory_sized with DEPTH_BYTES=256.
// A byte-array reference model predicts every registered output. The bench
// runs a directed sequence first and then a randomized sequence.

module tb_data_memory_sized;

    localparam int DEPTH = 256;

    logic        clk;
    logic        reset_n;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] Mem_Addr;
    logic [2:0]  Funct3;
    logic [63:0] Write_Data;
    logic [63:0] Read_Data;
    logic        Read_Valid;
    logic        Misaligned;
    logic        AccessFault;

    int          total_checks;
    int          bad_checks;

    logic [7:0]  ref_mem [DEPTH];
    logic [63:0] exp_rd;

    data_memory_sized #(
        .DEPTH_BYTES(DEPTH),
        .ADDR_WIDTH (64)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Mem_Addr   (Mem_Addr),
        .Funct3     (Funct3),
        .Write_Data (Write_Data),
        .Read_Data  (Read_Data),
        .Read_Valid (Read_Valid),
        .Misaligned (Misaligned),
        .AccessFault(AccessFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it fails.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Clear the reference model to its post-reset contents.
    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        exp_rd = 64'd0;
    endtask

    // Drive one access and let the DUT sample it at the next edge.
    // Predict the outcome from the model and check all four outputs.
    // Then update the model.
    task automatic applyStimulus(input logic wr, input logic rd,
                                 input logic [63:0] addr, input logic [2:0] f3,
                                 input logic [63:0] wdata, input string tag);
        int          size;
        logic        active;
        logic        mis;
        logic        fault;
        logic        good;
        logic [64:0] end_a;
        logic [63:0] value;
        int          base;
        @(negedge clk);
        MemWrite   = wr;
        MemRead    = rd;
        Mem_Addr   = addr;
        Funct3     = f3;
        Write_Data = wdata;
        @(posedge clk);
        #1;
        size   = 1 << f3[1:0];
        active = wr | rd;
        mis    = active && ((addr % 64'(size)) != 64'd0);
        end_a  = {1'b0, addr} + 65'(size);
        fault  = active && (f3 == 3'b111 || end_a > 65'(DEPTH) || (wr && f3[2]));
        good   = active && !mis && !fault;
        base   = good ? int'(addr[7:0]) : 0;
        if (rd) begin
            value = 64'd0;
            if (good) begin
                for (int k = size - 1; k >= 0; k--) value = {value[55:0], ref_mem[base + k]};
                if (!f3[2] && size < 8 && value[8*size-1]) value = value | (~64'd0 << (8*size));
            end
            exp_rd = value;
        end
        if (wr && good) begin
            for (int k = 0; k < size; k++) ref_mem[base + k] = wdata[8*k +: 8];
        end
        checkOutput({tag, ".data"},  Read_Data,          exp_rd);
        checkOutput({tag, ".valid"}, 64'(Read_Valid),    64'(rd));
        checkOutput({tag, ".mis"},   64'(Misaligned),    64'(mis));
        checkOutput({tag, ".fault"}, 64'(AccessFault),   64'(fault));
    endtask

    initial begin
        logic [63:0] r_addr;
        logic [63:0] r_data;
        logic [2:0]  r_f3;
        logic        r_wr;
        logic        r_rd;
        int          sel;

        total_checks = 0;
        bad_checks   = 0;
        reset_n      = 1'b0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        Mem_Addr     = '0;
        Funct3       = '0;
        Write_Data   = '0;
        clearModel();

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst.data",  Read_Data,         64'd0);
        checkOutput("rst.valid", 64'(Read_Valid),   64'd0);
        checkOutput("rst.mis",   64'(Misaligned),   64'd0);
        checkOutput("rst.fault", 64'(AccessFault),  64'd0);
        reset_n = 1'b1;

        // Directed sequence
        applyStimulus(0, 1, 64'd0, 3'b011, 64'd0, "ld0");
        checkOutput("ld0.lit", Read_Data, 64'd0);
        applyStimulus(0, 0, 64'd0, 3'b000, 64'd0, "idle0");
        applyStimulus(1, 0, 64'd8, 3'b011, 64'h8877665544332211, "sd8");
        applyStimulus(0, 1, 64'd8,  3'b000, 64'd0, "lb8");
        checkOutput("lb8.lit", Read_Data, 64'h11);
        applyStimulus(0, 1, 64'd10, 3'b001, 64'd0, "lh10");
        checkOutput("lh10.lit", Read_Data, 64'h4433);
        applyStimulus(0, 1, 64'd12, 3'b010, 64'd0, "lw12");
        checkOutput("lw12.lit", Read_Data, 64'hFFFFFFFF88776655);
        applyStimulus(0, 1, 64'd12, 3'b110, 64'd0, "lwu12");
        checkOutput("lwu12.lit", Read_Data, 64'h0000000088776655);
        applyStimulus(0, 1, 64'd15, 3'b100, 64'd0, "lbu15");
        checkOutput("lbu15.lit", Read_Data, 64'h88);
        applyStimulus(1, 0, 64'd9, 3'b000, 64'hAB, "sb9");
        applyStimulus(0, 1, 64'd8, 3'b011, 64'd0, "ld8");
        checkOutput("ld8.lit", Read_Data, 64'h887766554433AB11);
        applyStimulus(0, 1, 64'd6, 3'b010, 64'd0, "lw6mis");
        checkOutput("lw6mis.lit", 64'(Misaligned), 64'd1);
        applyStimulus(0, 0, 64'd0, 3'b000, 64'd0, "idle1");
        applyStimulus(1, 0, 64'd3, 3'b001, 64'hFFFF, "sh3mis");
        applyStimulus(0, 1, 64'd0, 3'b011, 64'd0, "ld0b");
        applyStimulus(1, 0, 64'd252, 3'b011, 64'hDEADBEEFCAFEF00D, "sd252");
        checkOutput("sd252.lit", 64'(AccessFault), 64'd1);
        applyStimulus(0, 1, 64'd248, 3'b011, 64'd0, "ld248");
        applyStimulus(0, 1, 64'd0, 3'b111, 64'd0, "f3ill");
        applyStimulus(0, 1, 64'h100, 3'b000, 64'd0, "lb256");
        applyStimulus(0, 1, 64'hFFFFFFFFFFFFFFF8, 3'b011, 64'd0, "ldhuge");
        applyStimulus(1, 1, 64'd16, 3'b100, 64'h1, "sbu16");
        applyStimulus(1, 0, 64'd16, 3'b011, 64'h7, "sd16a");
        applyStimulus(1, 1, 64'd16, 3'b011, 64'h5, "rw16");
        checkOutput("rw16.lit", Read_Data, 64'h7);
        applyStimulus(0, 1, 64'd16, 3'b011, 64'd0, "ld16");
        checkOutput("ld16.lit", Read_Data, 64'h5);

        // Asynchronous reset between edges
        @(negedge clk);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        clearModel();
        checkOutput("arst.data",  Read_Data,        64'd0);
        checkOutput("arst.valid", 64'(Read_Valid),  64'd0);
        checkOutput("arst.mis",   64'(Misaligned),  64'd0);
        checkOutput("arst.fault", 64'(AccessFault), 64'd0);
        MemRead = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("arst.hold", 64'(Read_Valid), 64'd0);
        reset_n = 1'b1;
        applyStimulus(0, 1, 64'd16, 3'b011, 64'd0, "ld16rst");
        checkOutput("ld16rst.lit", Read_Data, 64'd0);

        // Randomized sequence
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      r_addr = {$urandom, $urandom};
            else if (sel == 1) r_addr = 64'($urandom_range(244, 263));
            else               r_addr = 64'($urandom_range(0, 255));
            r_data = {$urandom, $urandom};
            r_f3   = 3'($urandom_range(0, 7));
            r_wr   = 1'($urandom_range(0, 1));
            r_rd   = 1'($urandom_range(0, 1));
            applyStimulus(r_wr, r_rd, r_addr, r_f3, r_data, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
